usb_tx_pkt: RTL and testbench

- Packet-level USB transmitter sitting directly downstream of the transaction engine.
- Consumes the txpkt_* request (start, PID, length, byte stream with per-byte ack).
- Serialises SYNC, PID, payload and CRC16 LSB-first as a bit stream to the low-level line encoder (NRZI/bit-stuff/EOP stage) over a per-bit ack handshake.
- Signals packet completion back with a done pulse.

---
 rtl/usb_tx_pkt_pkg.sv | 45 ++++
 rtl/usb_crc16.sv | 35 +++
 rtl/usb_tx_pkt.sv | 204 ++++++++++++++++++++
 tb/tb_usb_tx_pkt.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkt_pkg.sv
// usb_tx_pkt_pkg: shared USB definitions for the packet transmitter and the
// bit-serial CRC16 block.
//   - PID_* codes and the PID class field decode
//   - CRC16 polynomial (normal and reflected), init value, reflected residual
//   - SYNC byte pattern
//   - transmitter FSM state type
package usb_tx_pkt_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    // PID[1:0] class field
    localparam logic [1:0] PID_CLASS_DATA      = 2'b11;
    localparam logic [1:0] PID_CLASS_HANDSHAKE = 2'b10;

    localparam logic [15:0] CRC16_POLY          = 16'h8005;
    localparam logic [15:0] CRC16_POLY_REFL     = 16'hA001;
    localparam logic [15:0] CRC16_INIT          = 16'hFFFF;
    // Good-packet residual (0x800D) as seen in the reflected register
    localparam logic [15:0] CRC16_RESIDUAL_REFL = 16'hB001;

    // Seven zeros then a one when sent LSB-first
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_DONE
    } tx_state_t;

    function automatic logic pid_is_data(input logic [3:0] pid);
        return pid[1:0] == PID_CLASS_DATA;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: bit-serial USB CRC16 (poly 0x8005, reflected, init 0xFFFF).
// Shared between the TX packetiser and the RX checker.
//   clk     : system clock
//   rst     : synchronous active-high reset (loads init value)
//   i_clear : synchronous re-initialise to 0xFFFF
//   i_en    : advance the CRC by one bit
//   i_bit   : data bit, fed in wire order (LSB of each byte first)
//   o_crc   : current register (reflected; complement before transmitting)
module usb_crc16
    import usb_tx_pkt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic        i_bit,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic        w_fb;

    assign w_fb = r_crc[0] ^ i_bit;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_crc <= CRC16_INIT;
        end else if (i_en) begin
            r_crc <= (r_crc >> 1) ^ (w_fb ? CRC16_POLY_REFL : '0);
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/usb_tx_pkt.sv
// usb_tx_pkt: packet-level USB transmitter. Takes a txpkt request (start,
// PID, length, byte stream with per-byte ack) and serialises SYNC, PID,
// payload and CRC16 LSB-first to the line encoder with a per-bit ack.
//   clk          : 48 MHz system clock
//   rst          : synchronous active-high reset
//   pkt_start    : request pulse, pkt_pid/pkt_len valid same cycle (IDLE only)
//   pkt_pid      : PID; [1:0]==11 is a data packet, anything else PID-only
//   pkt_len      : payload byte count for data packets
//   pkt_data     : current payload byte (valid 1 cycle after pkt_data_ack)
//   pkt_data_ack : pulse, pkt_data consumed
//   pkt_done     : pulse one cycle after the final bit was acked
//   ll_start     : pulse with the first valid ll_bit of a packet
//   ll_bit       : bit on offer, held until ll_ack
//   ll_last      : ll_bit is the final bit of the packet
//   ll_ack       : line encoder consumed ll_bit
module usb_tx_pkt
    import usb_tx_pkt_pkg::*;
#(
    parameter bit SEND_SYNC = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_start,
    output logic       pkt_done,
    input  logic [3:0] pkt_pid,
    input  logic [9:0] pkt_len,
    input  logic [7:0] pkt_data,
    output logic       pkt_data_ack,
    output logic       ll_start,
    output logic       ll_bit,
    output logic       ll_last,
    input  logic       ll_ack
);

    tx_state_t   r_state,   w_state_nxt;
    logic [7:0]  r_shift,   w_shift_nxt;
    logic [2:0]  r_bitcnt,  w_bitcnt_nxt;
    logic [9:0]  r_bytecnt, w_bytecnt_nxt;
    logic [3:0]  r_pid,     w_pid_nxt;
    logic        r_is_data, w_is_data_nxt;
    logic        r_crc_hi,  w_crc_hi_nxt;
    logic        r_ll_start, w_ll_start_nxt;

    logic        w_byte_end;
    logic        w_data_ack;
    logic        w_crc_clear;
    logic        w_crc_en;
    logic        w_active;
    logic [3:0]  w_crc_idx;
    logic [15:0] w_crc;

    usb_crc16 u_crc (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_crc_clear),
        .i_en    (w_crc_en),
        .i_bit   (r_shift[0]),
        .o_crc   (w_crc)
    );

    assign w_byte_end = ll_ack && (r_bitcnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_bytecnt  <= '0;
            r_pid      <= '0;
            r_is_data  <= 1'b0;
            r_crc_hi   <= 1'b0;
            r_ll_start <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_bytecnt  <= w_bytecnt_nxt;
            r_pid      <= w_pid_nxt;
            r_is_data  <= w_is_data_nxt;
            r_crc_hi   <= w_crc_hi_nxt;
            r_ll_start <= w_ll_start_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bitcnt_nxt   = r_bitcnt;
        w_bytecnt_nxt  = r_bytecnt;
        w_pid_nxt      = r_pid;
        w_is_data_nxt  = r_is_data;
        w_crc_hi_nxt   = r_crc_hi;
        w_ll_start_nxt = 1'b0;
        w_data_ack     = 1'b0;
        w_crc_clear    = 1'b0;
        w_crc_en       = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (pkt_start) begin
                    w_pid_nxt      = pkt_pid;
                    w_is_data_nxt  = pid_is_data(pkt_pid);
                    w_bytecnt_nxt  = pkt_len;
                    w_bitcnt_nxt   = '0;
                    w_crc_hi_nxt   = 1'b0;
                    w_crc_clear    = 1'b1;
                    w_ll_start_nxt = 1'b1;
                    if (SEND_SYNC) begin
                        w_state_nxt = ST_SYNC;
                        w_shift_nxt = SYNC_BYTE;
                    end else begin
                        w_state_nxt = ST_PID;
                        w_shift_nxt = {~pkt_pid, pkt_pid};
                    end
                end
            end

            ST_SYNC: begin
                if (ll_ack) begin
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    if (w_byte_end) begin
                        w_state_nxt = ST_PID;
                        w_shift_nxt = {~r_pid, r_pid};
                    end
                end
            end

            ST_PID: begin
                if (ll_ack) begin
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    if (w_byte_end) begin
                        if (r_is_data && (r_bytecnt != '0)) begin
                            w_state_nxt   = ST_DATA;
                            w_shift_nxt   = pkt_data;
                            w_data_ack    = 1'b1;
                            w_bytecnt_nxt = r_bytecnt - 10'd1;
                        end else if (r_is_data) begin
                            w_state_nxt = ST_CRC;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (ll_ack) begin
                    w_crc_en     = 1'b1;
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    if (w_byte_end) begin
                        if (r_bytecnt != '0) begin
                            w_shift_nxt   = pkt_data;
                            w_data_ack    = 1'b1;
                            w_bytecnt_nxt = r_bytecnt - 10'd1;
                        end else begin
                            w_state_nxt = ST_CRC;
                        end
                    end
                end
            end

            // CRC register is frozen here, so bits are indexed straight out of
            // it instead of being copied into the shift register; this avoids
            // needing the post-update value at the DATA->CRC edge.
            ST_CRC: begin
                if (ll_ack) begin
                    w_bitcnt_nxt = r_bitcnt + 3'd1;
                    if (w_byte_end) begin
                        if (r_crc_hi) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_crc_hi_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_active  = (r_state == ST_SYNC) || (r_state == ST_PID) ||
                       (r_state == ST_DATA);
    assign w_crc_idx = {r_crc_hi, r_bitcnt};

    assign ll_bit       = (r_state == ST_CRC) ? ~w_crc[w_crc_idx] :
                          (w_active & r_shift[0]);
    assign ll_last      = (r_bitcnt == 3'd7) &&
                          (((r_state == ST_PID) && !r_is_data) ||
                           ((r_state == ST_CRC) && r_crc_hi));
    assign ll_start     = r_ll_start;
    assign pkt_done     = (r_state == ST_DONE);
    assign pkt_data_ack = w_data_ack;

endmodule

// File: tb/tb_usb_tx_pkt.sv
module tb_usb_tx_pkt;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_start;
    logic       pkt_done;
    logic [3:0] pkt_pid;
    logic [9:0] pkt_len;
    logic [7:0] pkt_data;
    logic       pkt_data_ack;
    logic       ll_start;
    logic       ll_bit;
    logic       ll_last;
    logic       ll_ack;

    always #5 clk = ~clk;

    usb_tx_pkt #(.SEND_SYNC(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_start    (pkt_start),
        .pkt_done     (pkt_done),
        .pkt_pid      (pkt_pid),
        .pkt_len      (pkt_len),
        .pkt_data     (pkt_data),
        .pkt_data_ack (pkt_data_ack),
        .ll_start     (ll_start),
        .ll_bit       (ll_bit),
        .ll_last      (ll_last),
        .ll_ack       (ll_ack)
    );

    typedef struct {
        string      name;
        logic [3:0] pid;
        int         len;
        int         gap;      // 0 = random 2..7 per bit
        bit         mid;      // pulse pkt_start mid-packet
        bit         setup;    // use the GET_DESCRIPTOR payload
        int         total;    // expected bits on the wire
        int         acks;     // expected pkt_data_ack pulses
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [7:0]  mem [1024];
    bit          exp_bits[$];
    bit          rec_bits[$];
    bit          rec_last[$];
    vec_t        vecs[7];

    task automatic check(input string tag, input string name,
                         input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, exp);
        end
    endtask

    // Reference: wire image built from the packet rules. CRC uses the
    // MSB-first register with poly 0x8005; its complement is sent MSB first,
    // which equals the reflected register sent LSB first.
    function automatic void build_expected(input logic [3:0] pid, input int len);
        logic [15:0] c;
        logic [7:0]  b;
        bit          d;
        bit          fb;
        exp_bits.delete();
        for (int i = 0; i < 8; i++) exp_bits.push_back(i == 7);
        b = {~pid, pid};
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (pid[1:0] == 2'b11) begin
            c = 16'hFFFF;
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < 8; i++) begin
                    d  = mem[k][i];
                    exp_bits.push_back(d);
                    fb = c[15] ^ d;
                    c  = {c[14:0], 1'b0};
                    if (fb) c = c ^ 16'h8005;
                end
            end
            c = ~c;
            for (int i = 15; i >= 0; i--) exp_bits.push_back(c[i]);
        end
    endfunction

    task automatic run_pkt(input string tag, input logic [3:0] pid, input int len,
                           input int gap, input bit mid, input int total,
                           input int acks);
        int last_ack_cyc, cur_gap, n_dack, n_start, n_done, done_cyc;
        int n_unstable, rd_ptr, budget, nmis, nlast;
        bit prev_valid, prev_ack, prev_bit, load_next, finished;
        build_expected(pid, len);
        rec_bits.delete();
        rec_last.delete();
        last_ack_cyc = -1;
        cur_gap = (gap == 0) ? int'($urandom_range(2, 7)) : gap;
        n_dack = 0; n_start = 0; n_done = 0; done_cyc = -100;
        n_unstable = 0; rd_ptr = 0; prev_valid = 0; prev_ack = 0; prev_bit = 0;
        load_next = 0; finished = 0;
        budget = exp_bits.size() * 9 + 40;

        @(negedge clk);
        pkt_start = 1'b1;
        pkt_pid   = pid;
        pkt_len   = len[9:0];
        pkt_data  = 8'($urandom);
        ll_ack    = 1'b0;

        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            // upstream buffer: first byte two cycles after start, then one
            // cycle after each ack
            if (cyc == 0) pkt_data = 8'($urandom);
            else if (cyc == 1) pkt_data = mem[0];
            else if (load_next) begin
                rd_ptr++;
                pkt_data = mem[rd_ptr % 1024];
            end
            load_next = 0;
            pkt_start = mid && (cyc == 20);
            if (pkt_start) begin
                pkt_pid = ~pid;
                pkt_len = 10'($urandom_range(1, 9));
            end
            ll_ack = (rec_bits.size() < exp_bits.size()) &&
                     (cyc - last_ack_cyc >= cur_gap);
            #1;
            if (ll_start) n_start++;
            if (cyc == 0) check(tag, "ll_start_first", ll_start, 1);
            if (pkt_data_ack) begin
                n_dack++;
                load_next = 1;
            end
            if (pkt_done) begin
                if (n_done == 0) done_cyc = cyc;
                n_done++;
            end
            if (prev_valid && !prev_ack && (ll_bit !== prev_bit)) n_unstable++;
            if (ll_ack) begin
                rec_bits.push_back(ll_bit);
                rec_last.push_back(ll_last);
                last_ack_cyc = cyc;
                cur_gap = (gap == 0) ? int'($urandom_range(2, 7)) : gap;
            end
            prev_valid = rec_bits.size() < exp_bits.size();
            prev_ack   = ll_ack;
            prev_bit   = ll_bit;
            if (rec_bits.size() == exp_bits.size() && cyc >= last_ack_cyc + 3)
                finished = 1;
        end
        ll_ack    = 1'b0;
        pkt_start = 1'b0;

        nmis = 0;
        nlast = 0;
        for (int i = 0; i < rec_bits.size() && i < exp_bits.size(); i++)
            if (rec_bits[i] != exp_bits[i]) nmis++;
        foreach (rec_last[i]) if (rec_last[i]) nlast++;
        check(tag, "bits", rec_bits.size(), total);
        check(tag, "stream_mismatches", nmis, 0);
        check(tag, "ll_last_count", nlast, 1);
        check(tag, "ll_last_on_final", (rec_last.size() > 0) ? rec_last[rec_last.size()-1] : 0, 1);
        check(tag, "data_acks", n_dack, acks);
        check(tag, "ll_start_pulses", n_start, 1);
        check(tag, "done_pulses", n_done, 1);
        check(tag, "done_after_last_ack", done_cyc - last_ack_cyc, 1);
        check(tag, "ll_bit_unstable", n_unstable, 0);
    endtask

    task automatic reset_abort();
        int n;
        int bad;
        n = 0;
        bad = 0;
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        @(negedge clk);
        pkt_start = 1'b1;
        pkt_pid   = 4'b0011;
        pkt_len   = 10'd8;
        @(negedge clk);
        pkt_start = 1'b0;
        for (int c = 0; c < 200 && n < 30; c++) begin
            @(negedge clk);
            pkt_data = 8'($urandom);
            ll_ack   = c[0];
            if (ll_ack) n++;
        end
        @(negedge clk);
        ll_ack = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_mid_data", "outputs_after_rst",
              {pkt_done, pkt_data_ack, ll_start, ll_bit, ll_last}, 0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            ll_ack = (c % 3 == 0);
            #1;
            if (pkt_done || pkt_data_ack || ll_start || ll_bit || ll_last) bad++;
        end
        ll_ack = 1'b0;
        check("reset_mid_data", "activity_after_abort", bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int          rlen;
        logic [3:0]  rpid;
        bit          isd;
        logic [7:0]  setup_bytes [8];

        setup_bytes = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        rst = 1'b1; pkt_start = 1'b0; pkt_pid = '0; pkt_len = '0;
        pkt_data = '0; ll_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset", "outputs", {pkt_done, pkt_data_ack, ll_start, ll_bit, ll_last}, 0);
        @(negedge clk);
        rst = 1'b0;

        vecs[0] = '{"ack",          4'b0010, 0,  2, 1'b0, 1'b0, 16, 0};
        vecs[1] = '{"data1_len0",   4'b1011, 0,  3, 1'b0, 1'b0, 32, 0};
        vecs[2] = '{"data0_fast",   4'b0011, 8,  2, 1'b0, 1'b1, 96, 8};
        vecs[3] = '{"data0_slow",   4'b0011, 8,  7, 1'b0, 1'b1, 96, 8};
        vecs[4] = '{"data0_midst",  4'b0011, 8,  3, 1'b1, 1'b1, 96, 8};
        vecs[5] = '{"nak_len50",    4'b1010, 50, 0, 1'b1, 1'b0, 16, 0};
        vecs[6] = '{"data1_len1",   4'b1011, 1,  0, 1'b0, 1'b0, 40, 1};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
            if (vecs[v].setup) for (int i = 0; i < 8; i++) mem[i] = setup_bytes[i];
            run_pkt(vecs[v].name, vecs[v].pid, vecs[v].len, vecs[v].gap,
                    vecs[v].mid, vecs[v].total, vecs[v].acks);
            if (v == 0) begin
                for (int i = 0; i < 16; i++) w[i] = rec_bits[i];
                check("ack", "wire_sync_pid", w, 16'hD280);
            end
            if (v == 2) begin
                for (int i = 0; i < 16; i++) w[i] = rec_bits[80 + i];
                check("data0_fast", "wire_crc", w, 16'h94DD);
            end
        end

        for (int r = 0; r < 12; r++) begin
            rpid = 4'($urandom);
            if (r % 2 == 0) rpid[1:0] = 2'b11;
            rlen = $urandom_range(0, 24);
            isd  = (rpid[1:0] == 2'b11);
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            run_pkt($sformatf("rand%0d", r), rpid, rlen,
                    (r % 3 == 0) ? 0 : int'($urandom_range(2, 7)), bit'($urandom_range(0, 1)),
                    isd ? 32 + 8 * rlen : 16, isd ? rlen : 0);
        end

        reset_abort();
        for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
        run_pkt("after_reset", 4'b0011, 3, 2, 1'b0, 56, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
